// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: fills p_RATIO lanes low-to-high and emits one wide beat.
// A narrow beat carrying last closes the wide beat early; unused upper lanes stay zero.
module stream_upsizer #(
    parameter int p_DATA_BITS = 32,
    parameter int p_STRB_BITS = 4,
    parameter int p_RATIO     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enq_valid,
    output logic                             enq_ready,
    input  logic [p_STRB_BITS-1:0]           enq_bits_strb,
    input  logic [p_DATA_BITS-1:0]           enq_bits_data,
    input  logic                             enq_bits_last,
    output logic                             deq_valid,
    input  logic                             deq_ready,
    output logic [p_STRB_BITS*p_RATIO-1:0]   deq_bits_strb,
    output logic [p_DATA_BITS*p_RATIO-1:0]   deq_bits_data,
    output logic                             deq_bits_last,
    output logic [$clog2(p_RATIO+1)-1:0]     count
);

    localparam int WD = p_DATA_BITS * p_RATIO;
    localparam int WS = p_STRB_BITS * p_RATIO;
    localparam int CW = $clog2(p_RATIO + 1);

    // Handshake: a beat moves on a port only in a cycle where its valid and ready are both high;
    // enq_ready depends on deq_ready only, and deq_* come straight from registers.
    // The state bit is observable directly as deq_valid (FILL=0, HOLD=1).
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   lane_q, lane_d;
    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic [WD-1:0]   data_q, data_d;
    logic [WS-1:0]   strb_q, strb_d;
    logic            last_q, last_d;
    logic            enq_fire;
    logic            deq_fire;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            lane_q  <= '0;
            hcnt_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            hcnt_q  <= hcnt_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hcnt_d  = hcnt_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (enq_fire) begin
                    for (int k = 0; k < p_RATIO; k++) begin
                        if (lane_q == CW'(k)) begin
                            data_d[k*p_DATA_BITS +: p_DATA_BITS] = enq_bits_data;
                            strb_d[k*p_STRB_BITS +: p_STRB_BITS] = enq_bits_strb;
                        end
                    end
                    last_d = enq_bits_last;
                    if (lane_q == CW'(p_RATIO - 1) || enq_bits_last) begin
                        state_d = HOLD;
                        hcnt_d  = lane_q + CW'(1);
                        lane_d  = '0;
                    end else begin
                        lane_d  = lane_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (deq_fire) begin
                    // New accumulation starts from a clean wide beat.
                    data_d = '0;
                    strb_d = '0;
                    last_d = 1'b0;
                    lane_d = '0;
                    state_d = FILL;
                    if (enq_fire) begin
                        data_d[p_DATA_BITS-1:0] = enq_bits_data;
                        strb_d[p_STRB_BITS-1:0] = enq_bits_strb;
                        last_d = enq_bits_last;
                        if (enq_bits_last) begin
                            state_d = HOLD;
                            hcnt_d  = CW'(1);
                        end else begin
                            lane_d  = CW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output logic
    always_comb begin
        deq_valid     = (state_q == HOLD);
        enq_ready     = !deq_valid || deq_ready;
        count         = deq_valid ? hcnt_q : lane_q;
        deq_bits_data = data_q;
        deq_bits_strb = strb_q;
        deq_bits_last = last_q;
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer (32-bit narrow, ratio 4): reset, packing, early last,
// backpressure, streaming and reset mid-accumulation with hand-computed expectations.
module tb_stream_upsizer;

    logic          clk;
    logic          rst_n;
    logic          enq_valid;
    logic          enq_ready;
    logic [3:0]    enq_bits_strb;
    logic [31:0]   enq_bits_data;
    logic          enq_bits_last;
    logic          deq_valid;
    logic          deq_ready;
    logic [15:0]   deq_bits_strb;
    logic [127:0]  deq_bits_data;
    logic          deq_bits_last;
    logic [2:0]    count;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    stream_upsizer #(.p_DATA_BITS(32), .p_STRB_BITS(4), .p_RATIO(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_bits_strb (enq_bits_strb),
        .enq_bits_data (enq_bits_data),
        .enq_bits_last (enq_bits_last),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_bits_strb (deq_bits_strb),
        .deq_bits_data (deq_bits_data),
        .deq_bits_last (deq_bits_last),
        .count         (count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One narrow beat, accepted in this cycle; enq_ready is checked before the edge.
    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
        enq_valid     = 1'b1;
        enq_bits_data = d;
        enq_bits_strb = s;
        enq_bits_last = l;
        #1;
        chk("send_enq_ready", enq_ready, 1'b1);
        tick();
        enq_valid     = 1'b0;
        enq_bits_last = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_deq_valid"}, deq_valid, 1'b0);
        chk({tag, "_data"}, deq_bits_data, 128'h0);
        chk({tag, "_strb"}, deq_bits_strb, 16'h0);
        chk({tag, "_last"}, deq_bits_last, 1'b0);
        chk({tag, "_count"}, count, 3'd0);
        chk({tag, "_enq_ready"}, enq_ready, 1'b1);
    endtask

    initial begin
        int n_wide;
        logic [127:0] held;

        rst_n         = 1'b0;
        enq_valid     = 1'b0;
        enq_bits_data = '0;
        enq_bits_strb = '0;
        enq_bits_last = 1'b0;
        deq_ready     = 1'b1;
        #2;
        chk_idle("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full packing
        send(32'h11111111, 4'hF, 1'b0);
        chk("pack_count1", count, 3'd1);
        send(32'h22222222, 4'hF, 1'b0);
        chk("pack_count2", count, 3'd2);
        send(32'h33333333, 4'hF, 1'b0);
        send(32'h44444444, 4'hF, 1'b0);
        chk("pack_valid", deq_valid, 1'b1);
        chk("pack_data", deq_bits_data, 128'h44444444_33333333_22222222_11111111);
        chk("pack_strb", deq_bits_strb, 16'hFFFF);
        chk("pack_last", deq_bits_last, 1'b0);
        chk("pack_count", count, 3'd4);
        tick();
        chk_idle("drain");

        // Early last, then a last-beat that lands in lane 0 while the held beat leaves
        send(32'h0000000A, 4'hF, 1'b0);
        send(32'h0000000B, 4'h3, 1'b1);
        chk("early_valid", deq_valid, 1'b1);
        chk("early_data", deq_bits_data, 128'h00000000_00000000_0000000B_0000000A);
        chk("early_strb", deq_bits_strb, 16'h003F);
        chk("early_last", deq_bits_last, 1'b1);
        chk("early_count", count, 3'd2);
        send(32'h0000000C, 4'h5, 1'b1);
        chk("lane0_valid", deq_valid, 1'b1);
        chk("lane0_data", deq_bits_data, 128'h0000000C);
        chk("lane0_strb", deq_bits_strb, 16'h0005);
        chk("lane0_last", deq_bits_last, 1'b1);
        chk("lane0_count", count, 3'd1);
        tick();
        chk_idle("drain2");

        // Backpressure
        deq_ready = 1'b0;
        send(32'h00000100, 4'hF, 1'b0);
        send(32'h00000101, 4'hF, 1'b0);
        send(32'h00000102, 4'hF, 1'b0);
        send(32'h00000103, 4'hF, 1'b0);
        enq_valid     = 1'b1;
        enq_bits_data = 32'h00000200;
        enq_bits_strb = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_enq_ready", enq_ready, 1'b0);
            chk("bp_valid", deq_valid, 1'b1);
            chk("bp_data", deq_bits_data, 128'h00000103_00000102_00000101_00000100);
            chk("bp_strb", deq_bits_strb, 16'hFFFF);
            chk("bp_count", count, 3'd4);
            tick();
        end
        deq_ready = 1'b1;
        #1;
        chk("bp_release_ready", enq_ready, 1'b1);
        tick();
        enq_valid = 1'b0;
        chk("bp_after_valid", deq_valid, 1'b0);
        chk("bp_after_count", count, 3'd1);
        send(32'h00000201, 4'hF, 1'b0);
        send(32'h00000202, 4'hF, 1'b0);
        send(32'h00000203, 4'hF, 1'b0);
        chk("bp_next_data", deq_bits_data, 128'h00000203_00000202_00000201_00000200);
        chk("bp_next_count", count, 3'd4);

        // Reset while a wide beat is held
        deq_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_idle("rst_hold");
        #1;
        rst_n = 1'b1;
        deq_ready = 1'b1;
        tick();

        // Streaming 16 beats with a scoreboard queue
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back({32'(4*w+4), 32'(4*w+3), 32'(4*w+2), 32'(4*w+1)});
        end
        n_wide = 0;
        for (int i = 0; i < 16; i++) begin
            enq_valid     = 1'b1;
            enq_bits_data = 32'(i + 1);
            enq_bits_strb = 4'hF;
            enq_bits_last = 1'b0;
            #1;
            chk("stream_enq_ready", enq_ready, 1'b1);
            tick();
            if (deq_valid) begin
                n_wide++;
                if (exp_q.size() > 0) begin
                    held = exp_q.pop_front();
                    chk("stream_data", deq_bits_data, held);
                end else begin
                    chk("stream_extra_beat", 1'b1, 1'b0);
                end
            end
        end
        enq_valid = 1'b0;
        chk("stream_wide_beats", 32'(n_wide), 32'd4);
        chk("stream_queue_left", 32'(exp_q.size()), 32'd0);
        tick();

        // Reset mid-accumulation
        send(32'h000000AA, 4'hF, 1'b0);
        send(32'h000000BB, 4'hF, 1'b0);
        chk("mid_count_before", count, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_data", deq_bits_data, 128'h0);
        #1;
        rst_n = 1'b1;
        tick();
        send(32'h1, 4'hF, 1'b0);
        send(32'h2, 4'hF, 1'b0);
        send(32'h3, 4'hF, 1'b0);
        send(32'h4, 4'hF, 1'b0);
        chk("mid_data", deq_bits_data, 128'h00000004_00000003_00000002_00000001);
        chk("mid_count", count, 3'd4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
